// File: rtl/regfile_dump_if.sv
// Word stream from the register dump engine to the debug/trace link.
interface regfile_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;

    modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// Walks a latched register index range through one register-file read port and
// streams each word with its index; holds off pipeline writes while dumping.
module regfile_dump (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           abort,
    input  logic [4:0]     first_reg,
    input  logic [4:0]     last_reg,
    output logic [4:0]     rd_sel,
    input  logic [31:0]    rd_data,
    regfile_dump_if.master stream,
    output logic           busy,
    output logic           hold,
    output logic           done
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

    state_t     state, state_n;
    logic [4:0] idx;
    logic [4:0] last_q;
    logic       load, capture, advance, drop;
    logic       xfer;

    assign xfer = stream.out_valid && stream.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    // Abort outranks a same-cycle handshake, so an aborted word is never counted.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        drop    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_READ;
                    load    = 1'b1;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_SEND;
                    capture = 1'b1;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_n = S_IDLE;
                    drop    = 1'b1;
                end else if (xfer) begin
                    drop = 1'b1;
                    if (idx == last_q) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_READ;
                        advance = 1'b1;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Index arithmetic is 5-bit and wraps 31 -> 0; rd_sel keeps its value in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx              <= 5'd0;
            last_q           <= 5'd0;
            rd_sel           <= 5'd0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= 32'd0;
            stream.out_idx   <= 5'd0;
        end else begin
            if (load) begin
                idx    <= first_reg;
                last_q <= last_reg;
                rd_sel <= first_reg;
            end
            if (capture) begin
                stream.out_data  <= rd_data;
                stream.out_idx   <= idx;
                stream.out_valid <= 1'b1;
            end
            if (advance) begin
                idx    <= idx + 5'd1;
                rd_sel <= idx + 5'd1;
            end
            if (drop) stream.out_valid <= 1'b0;
        end
    end

    // Status outputs decode the state register directly, so they carry no rd_data path.
    assign busy            = (state == S_READ) || (state == S_SEND);
    assign hold            = busy;
    assign done            = (state == S_DONE);
    assign stream.out_last = stream.out_valid && (stream.out_idx == last_q);
endmodule
